// File: rtl/fifo_wptr_full_ctrl_if.sv
// Write-side handshake bundle for the async FIFO write pointer/flag controller.
// The master modport is the producer/testbench; the slave modport is the controller.
interface fifo_wptr_full_ctrl_if #(
  parameter int unsigned ADDRSIZE = 4
);
  logic                wr_en;
  logic [ADDRSIZE:0]   rgray_sync;
  logic                ovf_clr;
  logic                wr_accept;
  logic [ADDRSIZE-1:0] wr_addr;
  logic [ADDRSIZE:0]   wgray;
  logic                full;
  logic                almost_full;
  logic [ADDRSIZE:0]   level;
  logic                overflow;

  modport master (
    output wr_en, rgray_sync, ovf_clr,
    input  wr_accept, wr_addr, wgray, full, almost_full, level, overflow
  );

  modport slave (
    input  wr_en, rgray_sync, ovf_clr,
    output wr_accept, wr_addr, wgray, full, almost_full, level, overflow
  );
endinterface

// File: rtl/fifo_wptr_full_ctrl.sv
// Write-domain pointer/flag controller: binary and Gray write pointers, full,
// almost_full, fill level and a sticky overflow flag, derived from the synchronized read pointer.
module fifo_wptr_full_ctrl #(
  parameter int unsigned ADDRSIZE  = 4,
  parameter int unsigned AF_THRESH = 14
) (
  input logic                   clk,
  input logic                   reset,
  fifo_wptr_full_ctrl_if.slave  bus
);
  localparam int unsigned PW = ADDRSIZE + 1;
  localparam logic [PW-1:0] AF_LVL = PW'(AF_THRESH);

  logic [PW-1:0] r_wbin;
  logic [PW-1:0] r_wgray;
  logic [PW-1:0] r_level;
  logic          r_full;
  logic          r_almost_full;
  logic          r_overflow;

  logic          w_accept;
  logic [PW-1:0] w_wbin_next;
  logic [PW-1:0] w_wgray_next;
  logic [PW-1:0] w_rgray_wrapped;
  logic [PW-1:0] w_rbin;
  logic [PW-1:0] w_level_next;
  logic          w_full_next;
  logic          w_almost_full_next;

  assign w_accept     = bus.wr_en & ~r_full;
  assign w_wbin_next  = r_wbin + PW'(w_accept);
  assign w_wgray_next = w_wbin_next ^ (w_wbin_next >> 1);

  // Full when the write pointer is one lap ahead: top two Gray bits inverted.
  assign w_rgray_wrapped = {~bus.rgray_sync[ADDRSIZE:ADDRSIZE-1], bus.rgray_sync[ADDRSIZE-2:0]};
  assign w_full_next     = (w_wgray_next == w_rgray_wrapped);

  // Gray to binary: each bit is the XOR of all Gray bits at or above it.
  always_comb begin
    w_rbin = '0;
    for (int unsigned i = 0; i < PW; i++) begin
      w_rbin[i] = ^(bus.rgray_sync >> i);
    end
  end

  assign w_level_next       = w_wbin_next - w_rbin;
  assign w_almost_full_next = (w_level_next >= AF_LVL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wbin        <= '0;
      r_wgray       <= '0;
      r_level       <= '0;
      r_full        <= 1'b0;
      r_almost_full <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_wbin        <= w_wbin_next;
      r_wgray       <= w_wgray_next;
      r_level       <= w_level_next;
      r_full        <= w_full_next;
      r_almost_full <= w_almost_full_next;
      // A write attempted while full takes priority over a clear request.
      if (bus.wr_en && r_full) begin
        r_overflow <= 1'b1;
      end else if (bus.ovf_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign bus.wr_accept   = w_accept;
  assign bus.wr_addr     = r_wbin[ADDRSIZE-1:0];
  assign bus.wgray       = r_wgray;
  assign bus.full        = r_full;
  assign bus.almost_full = r_almost_full;
  assign bus.level       = r_level;
  assign bus.overflow    = r_overflow;
endmodule

// File: tb/tb_fifo_wptr_full_ctrl.sv
// Self-checking bench for fifo_wptr_full_ctrl: a count-based occupancy model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_fifo_wptr_full_ctrl;
  localparam int unsigned A  = 4;
  localparam int unsigned AF = 14;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  bit   check_en;

  fifo_wptr_full_ctrl_if #(.ADDRSIZE(A)) bus ();

  fifo_wptr_full_ctrl #(.ADDRSIZE(A), .AF_THRESH(AF)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] gray(input int b);
    logic [4:0] v;
    v = 5'(b);
    return v ^ (v >> 1);
  endfunction

  // Brute-force decode: find the count whose Gray code matches.
  function automatic int ungray(input logic [4:0] g);
    for (int b = 0; b < 32; b++) begin
      if (gray(b) == g) return b;
    end
    return 0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Occupancy model: count of accepted writes versus reads implied by the read pointer.
  int m_wcnt;
  int m_level;
  bit m_full;
  bit m_af;
  bit m_ovf;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_wcnt = 0; m_level = 0; m_full = 0; m_af = 0; m_ovf = 0;
    end else begin
      if (bus.wr_en && m_full) m_ovf = 1;
      else if (bus.ovf_clr)    m_ovf = 0;
      if (bus.wr_en && !m_full) m_wcnt = (m_wcnt + 1) % 32;
      m_level = (m_wcnt - ungray(bus.rgray_sync) + 32) % 32;
      m_full  = (m_level == 16);
      m_af    = (m_level >= AF);
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("wr_accept",   int'(bus.wr_accept),   int'(bus.wr_en && !m_full));
      chk("wr_addr",     int'(bus.wr_addr),     m_wcnt % 16);
      chk("wgray",       int'(bus.wgray),       int'(gray(m_wcnt)));
      chk("level",       int'(bus.level),       m_level);
      chk("full",        int'(bus.full),        int'(m_full));
      chk("almost_full", int'(bus.almost_full), int'(m_af));
      chk("overflow",    int'(bus.overflow),    int'(m_ovf));
    end
  end

  task automatic drive(input logic we, input logic [4:0] rg, input logic clr);
    @(negedge clk);
    #1;
    bus.wr_en      = we;
    bus.rgray_sync = rg;
    bus.ovf_clr    = clr;
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  int         k;
  logic [4:0] prev_wgray;
  bit         saw_wrap;

  initial begin
    checks = 0; errors = 0; check_en = 0;
    reset = 1'b1;
    bus.wr_en = 1'b0; bus.rgray_sync = '0; bus.ovf_clr = 1'b0;
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    check_en = 1;
    chk("rst_level", int'(bus.level), 0);
    chk("rst_full",  int'(bus.full), 0);

    // 1: reset mid-stream with wbin=5
    repeat (5) drive(1'b1, 5'd0, 1'b0);
    settle();
    chk("pre_rst_addr", int'(bus.wr_addr), 5);
    @(negedge clk);
    #1;
    reset = 1'b1;
    bus.wr_en = 1'b0;
    #1;
    chk("midrst_addr",  int'(bus.wr_addr), 0);
    chk("midrst_wgray", int'(bus.wgray), 0);
    chk("midrst_level", int'(bus.level), 0);
    chk("midrst_full",  int'(bus.full), 0);
    chk("midrst_af",    int'(bus.almost_full), 0);
    chk("midrst_ovf",   int'(bus.overflow), 0);
    chk("midrst_acc",   int'(bus.wr_accept), 0);
    @(negedge clk);
    #1 reset = 1'b0;

    // 2: fill from empty
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 5'd0, 1'b0);
      settle();
      if (i == 12) chk("af_at_13", int'(bus.almost_full), 0);
      if (i == 13) chk("af_at_14", int'(bus.almost_full), 1);
      if (i == 14) chk("full_at_15", int'(bus.full), 0);
    end
    chk("fill_level", int'(bus.level), 16);
    chk("fill_full",  int'(bus.full), 1);
    chk("fill_af",    int'(bus.almost_full), 1);
    chk("fill_wgray", int'(bus.wgray), int'(5'b11000));

    // 3: writes while full are rejected and set overflow
    repeat (3) drive(1'b1, 5'd0, 1'b0);
    drive(1'b0, 5'd0, 1'b0);
    settle();
    chk("ovf_set",   int'(bus.overflow), 1);
    chk("ovf_addr",  int'(bus.wr_addr), 0);
    chk("ovf_wgray", int'(bus.wgray), int'(5'b11000));

    // 4: one read frees a slot, one write refills
    drive(1'b0, 5'b00001, 1'b0);
    settle();
    chk("read_full",  int'(bus.full), 0);
    chk("read_level", int'(bus.level), 15);
    drive(1'b1, 5'b00001, 1'b0);
    settle();
    chk("refill_full",  int'(bus.full), 1);
    chk("refill_level", int'(bus.level), 16);

    // 5: set beats clear, then clear alone
    drive(1'b1, 5'b00001, 1'b1);
    settle();
    chk("ovf_set_wins", int'(bus.overflow), 1);
    drive(1'b0, 5'b00001, 1'b1);
    settle();
    chk("ovf_cleared", int'(bus.overflow), 0);

    // 6: wrap with the read pointer trailing by two
    k = 17;
    drive(1'b0, gray(k - 2), 1'b0);
    settle();
    chk("wrap_start_level", int'(bus.level), 2);
    saw_wrap = 0;
    prev_wgray = bus.wgray;
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, gray((k - 1) & 31), 1'b0);
      k = (k + 1) % 32;
      settle();
      chk("wrap_level", int'(bus.level), 2);
      chk("wrap_full",  int'(bus.full), 0);
      if (prev_wgray == 5'b10000 && bus.wgray == 5'b00000) saw_wrap = 1;
      prev_wgray = bus.wgray;
    end
    chk("wrap_seen",  int'(saw_wrap), 1);
    chk("wrap_wgray", int'(bus.wgray), int'(5'b10101));
    chk("wrap_addr",  int'(bus.wr_addr), 9);
    drive(1'b0, gray(k - 2), 1'b0);
    repeat (2) @(negedge clk);

    check_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
